// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the board SRAM access arbiter.
//   SRAM_AW / SRAM_DW : SRAM address and data widths.
//   state_t           : arbiter FSM states.
//   sram_strb_t       : bundle of the active-low SRAM strobes.
//   strb_for()        : strobe levels to present while in a given state.
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic lb_n;
        logic ub_n;
    } sram_strb_t;

    // Write and read both enable the chip and both byte lanes; only the
    // direction strobe differs. Every other state parks the bus inactive.
    function automatic sram_strb_t strb_for(input state_t s);
        sram_strb_t st;
        st = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};
        case (s)
            S_WRITE: st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, lb_n: 1'b0, ub_n: 1'b0};
            S_READ:  st = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, lb_n: 1'b0, ub_n: 1'b0};
            default: st = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
// Shares the single 16-bit board SRAM between the recorder (writes) and the
// player (reads). Writes have fixed priority, but after WR_BURST_MAX write
// grants made while a read was waiting, the next contested grant goes to the
// read. Each access holds the strobes for ACC_CYC cycles, followed by one
// recovery cycle (all strobes high, bus released) that carries the ack/valid.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wr_req/addr/data      write request (level, held until o_wr_ack)
//   o_wr_ack                one-cycle pulse, write completed
//   i_rd_req/addr           read request (level, held until o_rd_valid)
//   o_rd_data, o_rd_valid   read word and its one-cycle completion pulse
//   o_busy                  high whenever the FSM is not idle
//   o_SRAM_*, io_SRAM_DQ    SRAM pins; DQ driven only during a write
// ---------------------------------------------------------------------------
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACC_CYC      = 2,
    parameter int WR_BURST_MAX = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_req,
    input  logic [SRAM_AW-1:0] i_wr_addr,
    input  logic [SRAM_DW-1:0] i_wr_data,
    output logic               o_wr_ack,
    input  logic               i_rd_req,
    input  logic [SRAM_AW-1:0] i_rd_addr,
    output logic [SRAM_DW-1:0] o_rd_data,
    output logic               o_rd_valid,
    output logic               o_busy,
    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);

    localparam int ACC_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam int STV_W = $clog2(WR_BURST_MAX + 1);

    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACC_CYC - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(WR_BURST_MAX);

    state_t             state;
    logic [ACC_W-1:0]   acc_cnt;
    logic [STV_W-1:0]   starve_cnt;
    logic [SRAM_DW-1:0] wr_data_q;
    logic               dq_oe;
    sram_strb_t         strb;

    logic grant_wr;
    logic grant_rd;

    // Arbitration: the read wins only when it is alone or when the write
    // streak seen by a waiting read has reached its limit.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (i_rd_req && (!i_wr_req || (starve_cnt == STV_MAX))) begin
            grant_rd = 1'b1;
        end else if (i_wr_req) begin
            grant_wr = 1'b1;
        end
    end

    // Bus driven only from a registered enable, so DQ can never glitch on
    // while OE_N is low.
    assign io_SRAM_DQ = dq_oe ? wr_data_q : {SRAM_DW{1'bz}};

    assign o_SRAM_CE_N = strb.ce_n;
    assign o_SRAM_OE_N = strb.oe_n;
    assign o_SRAM_WE_N = strb.we_n;
    assign o_SRAM_LB_N = strb.lb_n;
    assign o_SRAM_UB_N = strb.ub_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            acc_cnt     <= '0;
            starve_cnt  <= '0;
            wr_data_q   <= '0;
            dq_oe       <= 1'b0;
            strb        <= strb_for(S_IDLE);
            o_SRAM_ADDR <= '0;
            o_rd_data   <= '0;
            o_wr_ack    <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_wr_ack   <= 1'b0;
            o_rd_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    acc_cnt <= '0;
                    if (grant_wr) begin
                        state       <= S_WRITE;
                        o_SRAM_ADDR <= i_wr_addr;
                        wr_data_q   <= i_wr_data;
                        dq_oe       <= 1'b1;
                        strb        <= strb_for(S_WRITE);
                        o_busy      <= 1'b1;
                        // A write taken while a read waits extends the
                        // streak; an uncontested write ends it.
                        if (!i_rd_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STV_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (grant_rd) begin
                        state       <= S_READ;
                        o_SRAM_ADDR <= i_rd_addr;
                        dq_oe       <= 1'b0;
                        strb        <= strb_for(S_READ);
                        o_busy      <= 1'b1;
                        starve_cnt  <= '0;
                    end
                end

                S_WRITE: begin
                    if (acc_cnt == ACC_LAST) begin
                        state    <= S_RECOVER;
                        acc_cnt  <= '0;
                        dq_oe    <= 1'b0;
                        strb     <= strb_for(S_RECOVER);
                        o_wr_ack <= 1'b1;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end

                S_READ: begin
                    if (acc_cnt == ACC_LAST) begin
                        // Data has been valid on the bus for the whole
                        // strobe window; capture before OE_N is released.
                        state      <= S_RECOVER;
                        acc_cnt    <= '0;
                        strb       <= strb_for(S_RECOVER);
                        o_rd_data  <= io_SRAM_DQ;
                        o_rd_valid <= 1'b1;
                    end else begin
                        acc_cnt <= acc_cnt + 1'b1;
                    end
                end

                S_RECOVER: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    acc_cnt <= '0;
                    dq_oe   <= 1'b0;
                    strb    <= strb_for(S_IDLE);
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_access_arbiter
// Directed bench for sram_access_arbiter (ACC_CYC = 2, WR_BURST_MAX = 4)
// with a small behavioural SRAM on the pins and a pull-up on DQ so that a
// released bus reads back as all ones.
// ---------------------------------------------------------------------------
module tb_sram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [19:0] rd_addr;

    logic        wr_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [19:0] sram_addr;
    wire  [15:0] dq;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;

    int vectors     = 0;
    int miscompares = 0;
    int wcount;
    logic exp_rd;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    sram_access_arbiter #(
        .ACC_CYC      (2),
        .WR_BURST_MAX (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_req    (wr_req),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_ack    (wr_ack),
        .i_rd_req    (rd_req),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_busy      (busy),
        .o_SRAM_ADDR (sram_addr),
        .io_SRAM_DQ  (dq),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    // Behavioural SRAM: drives DQ only while output-enabled for a read.
    pullup (dq);
    assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[7:0]] <= dq;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; every cycle also
    // confirms WE_N and OE_N are never asserted together.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("we_oe_exclusive", 32'(!(we_n == 1'b0 && oe_n == 1'b0)), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_ce_n",   32'(ce_n), 32'd1);
        chk("rst_we_n",   32'(we_n), 32'd1);
        chk("rst_oe_n",   32'(oe_n), 32'd1);
        chk("rst_lb_ub",  32'({lb_n, ub_n}), 32'd3);
        chk("rst_addr",   32'(sram_addr), 32'd0);
        chk("rst_dq_z",   32'(dq), 32'hFFFF);
        chk("rst_ack",    32'(wr_ack), 32'd0);
        chk("rst_valid",  32'(rd_valid), 32'd0);
        chk("rst_rdata",  32'(rd_data), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);

        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_busy",  32'(busy), 32'd0);
        chk("idle_ce_n",  32'(ce_n), 32'd1);
        chk("idle_dq_z",  32'(dq), 32'hFFFF);

        // Single write 0xBEEF -> 0x00010
        wr_addr = 20'h00010;
        wr_data = 16'hBEEF;
        wr_req  = 1'b1;
        tick();
        chk("wr1_we_n",   32'(we_n), 32'd0);
        chk("wr1_ce_n",   32'(ce_n), 32'd0);
        chk("wr1_oe_n",   32'(oe_n), 32'd1);
        chk("wr1_lb_ub",  32'({lb_n, ub_n}), 32'd0);
        chk("wr1_addr",   32'(sram_addr), 32'h10);
        chk("wr1_dq",     32'(dq), 32'hBEEF);
        chk("wr1_busy",   32'(busy), 32'd1);
        chk("wr1_ack",    32'(wr_ack), 32'd0);
        tick();
        chk("wr2_we_n",   32'(we_n), 32'd0);
        chk("wr2_dq",     32'(dq), 32'hBEEF);
        chk("wr2_ack",    32'(wr_ack), 32'd0);
        tick();
        chk("wr_rec_ack", 32'(wr_ack), 32'd1);
        chk("wr_rec_we",  32'(we_n), 32'd1);
        chk("wr_rec_ce",  32'(ce_n), 32'd1);
        chk("wr_rec_dqz", 32'(dq), 32'hFFFF);
        chk("wr_rec_bsy", 32'(busy), 32'd1);
        wr_req = 1'b0;
        tick();
        chk("wr_idle_ack", 32'(wr_ack), 32'd0);
        chk("wr_idle_bsy", 32'(busy), 32'd0);
        chk("wr_mem",      32'(mem[8'h10]), 32'hBEEF);

        // Read back 0x00010, dropping the request mid-access
        rd_addr = 20'h00010;
        rd_req  = 1'b1;
        tick();
        chk("rd1_oe_n",   32'(oe_n), 32'd0);
        chk("rd1_we_n",   32'(we_n), 32'd1);
        chk("rd1_ce_n",   32'(ce_n), 32'd0);
        chk("rd1_addr",   32'(sram_addr), 32'h10);
        chk("rd1_dq",     32'(dq), 32'hBEEF);
        chk("rd1_valid",  32'(rd_valid), 32'd0);
        rd_req = 1'b0;
        tick();
        chk("rd2_oe_n",   32'(oe_n), 32'd0);
        chk("rd2_valid",  32'(rd_valid), 32'd0);
        tick();
        chk("rd_valid",   32'(rd_valid), 32'd1);
        chk("rd_data",    32'(rd_data), 32'hBEEF);
        chk("rd_rec_oe",  32'(oe_n), 32'd1);
        tick();
        chk("rd_vld_low", 32'(rd_valid), 32'd0);
        chk("rd_hold1",   32'(rd_data), 32'hBEEF);
        tick();
        chk("rd_hold2",   32'(rd_data), 32'hBEEF);
        chk("rd_idle",    32'(busy), 32'd0);

        // Both requests held: expect W,W,W,W,R,W,W,W,W,R
        wcount  = 0;
        wr_addr = 20'h00100;
        wr_data = 16'h1000;
        rd_addr = 20'h00102;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_rd = ((g % 5) == 4);
            tick();
            chk("burst_oe_n", 32'(oe_n), exp_rd ? 32'd0 : 32'd1);
            chk("burst_we_n", 32'(we_n), exp_rd ? 32'd1 : 32'd0);
            if (!exp_rd) begin
                chk("burst_waddr", 32'(sram_addr), 32'h100 + 32'(wcount));
                chk("burst_wdq",   32'(dq), 32'h1000 + 32'(wcount));
                wr_addr = 20'hFFFFF;
                wr_data = 16'hDEAD;
                wcount++;
            end else begin
                chk("burst_raddr", 32'(sram_addr), 32'h102);
            end
            tick();
            if (!exp_rd) begin
                chk("burst_addr_latched", 32'(sram_addr), 32'h100 + 32'(wcount - 1));
                chk("burst_dq_latched",   32'(dq), 32'h1000 + 32'(wcount - 1));
            end
            tick();
            chk("burst_ack",   32'(wr_ack), exp_rd ? 32'd0 : 32'd1);
            chk("burst_valid", 32'(rd_valid), exp_rd ? 32'd1 : 32'd0);
            if (exp_rd) chk("burst_rdata", 32'(rd_data), 32'h1002);
            tick();
            chk("burst_idle_bsy", 32'(busy), 32'd0);
            chk("burst_idle_ack", 32'(wr_ack), 32'd0);
            wr_addr = 20'h00100 + 20'(wcount);
            wr_data = 16'h1000 + 16'(wcount);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        chk("post_burst_bsy", 32'(busy), 32'd0);
        chk("post_burst_ce",  32'(ce_n), 32'd1);

        // Asynchronous reset in the middle of a write
        wr_addr = 20'h00030;
        wr_data = 16'h5555;
        wr_req  = 1'b1;
        tick();
        chk("arst_pre_we", 32'(we_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we_n",  32'(we_n), 32'd1);
        chk("arst_ce_n",  32'(ce_n), 32'd1);
        chk("arst_oe_n",  32'(oe_n), 32'd1);
        chk("arst_dq_z",  32'(dq), 32'hFFFF);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_addr",  32'(sram_addr), 32'd0);
        wr_req = 1'b0;
        tick();
        tick();
        chk("arst_no_ack", 32'(wr_ack), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_post_ack",  32'(wr_ack), 32'd0);
        chk("arst_post_busy", 32'(busy), 32'd0);
        chk("arst_post_ce",   32'(ce_n), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
